// File: rtl/uart_rx_if.sv
// uart_rx_if: tick, serial line and received-byte signals of uart_rx.
// The parity_err member exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(parameter int DBIT = 8);
  logic s_tick;
  logic rx;
  logic [DBIT-1:0] rx_data;
  logic rx_done;
  logic frame_err;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  modport master(input s_tick, rx, output rx_data, rx_done, frame_err, parity_err);
  modport slave(output s_tick, rx, input rx_data, rx_done, frame_err, parity_err);
`else
  modport master(input s_tick, rx, output rx_data, rx_done, frame_err);
  modport slave(output s_tick, rx, input rx_data, rx_done, frame_err);
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver with mid-bit sampling, frame error and break hold.
// Optional even-parity check (8E1) is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DBIT = 8,
  parameter int OVERSAMPLE = 16
) (
  input logic clk,
  input logic rst_n,
  uart_rx_if.master bus
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t state, state_nxt;
  logic [1:0] sync;
  logic [SW-1:0] s, s_nxt;
  logic [NW-1:0] n, n_nxt;
  logic [DBIT-1:0] shreg;
  logic rx_s, mid, last, shift, fin;
`ifdef UART_RX_PARITY_EN
  logic par, par_ld;
`endif
  assign rx_s = sync[1];
  assign mid = bus.s_tick && s == SW'(OVERSAMPLE / 2 - 1);
  assign last = bus.s_tick && s == SW'(OVERSAMPLE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      state <= IDLE;
      s <= '0;
      n <= '0;
      shreg <= '0;
      bus.rx_data <= '0;
      bus.rx_done <= 1'b0;
      bus.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par <= 1'b0;
      bus.parity_err <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], bus.rx};
      state <= state_nxt;
      s <= s_nxt;
      n <= n_nxt;
      if (shift) shreg <= {rx_s, shreg[DBIT-1:1]};
      bus.rx_done <= fin;
      if (fin) begin
        bus.rx_data <= shreg;
        bus.frame_err <= ~rx_s;
      end
`ifdef UART_RX_PARITY_EN
      if (par_ld) par <= rx_s;
      if (fin) bus.parity_err <= ^{shreg, par};
`endif
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = rx_s ? IDLE : START;
      START: state_nxt = mid ? (rx_s ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA: state_nxt = (last && n == NW'(DBIT - 1)) ? PARITY : DATA;
      PARITY: state_nxt = last ? STOP : PARITY;
`else
      DATA: state_nxt = (last && n == NW'(DBIT - 1)) ? STOP : DATA;
`endif
      STOP: state_nxt = last ? (rx_s ? IDLE : BRK) : STOP;
      BRK: state_nxt = rx_s ? IDLE : BRK;
      default: state_nxt = IDLE;
    endcase
  end
  // Any state change, and every bit-period wrap, restarts the tick count.
  always_comb begin
    s_nxt = (state_nxt != state || last) ? '0 :
            (bus.s_tick && state != IDLE && state != BRK) ? s + SW'(1) : s;
    n_nxt = state == START ? '0 : shift ? n + NW'(1) : n;
  end
  always_comb begin
    shift = state == DATA && last;
    fin = state == STOP && last;
`ifdef UART_RX_PARITY_EN
    par_ld = state == PARITY && last;
`endif
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; expected bytes are queued and checked by a monitor.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] tc;
  always #5 clk = ~clk;
  uart_rx_if #(.DBIT(8)) bus();
  uart_rx #(.DBIT(8), .OVERSAMPLE(16)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tc <= 2'd0;
    else tc <= tc + 2'd1;
  assign bus.s_tick = tc == 2'd3;
  typedef struct {
    logic [7:0] d;
    logic fe;
    logic pe;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int vecs = 0;
  int errs = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.rx_done) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_done got data=%0h want no pulse", bus.rx_data);
      end else begin
        me = q.pop_front();
        chk("rx_data", 32'(bus.rx_data), 32'(me.d));
        chk("frame_err", 32'(bus.frame_err), 32'(me.fe));
`ifdef UART_RX_PARITY_EN
        chk("parity_err", 32'(bus.parity_err), 32'(me.pe));
`endif
      end
    end
  task automatic drive(input logic b, input int cycles);
    #1 bus.rx = b;
    repeat (cycles) @(posedge clk);
  endtask
  // One bit period is 16 ticks of 4 clocks each.
  task automatic send(input logic [7:0] d, input logic stop, input logic par_flip);
    exp_t e;
    e.d = d;
    e.fe = ~stop;
    e.pe = par_flip;
    q.push_back(e);
    drive(1'b0, 64);
    for (int i = 0; i < 8; i++) drive(d[i], 64);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ par_flip, 64);
`endif
    drive(stop, 64);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(bus.rx_data), 32'h0);
    chk("reset_done", 32'(bus.rx_done), 32'h0);
    chk("reset_ferr", 32'(bus.frame_err), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 20);
    send(8'h55, 1'b1, 1'b0);
    drive(1'b1, 128);
    send(8'hAB, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    drive(1'b1, 128);
    drive(1'b0, 12);
    drive(1'b1, 200);
    chk("glitch_hold_data", 32'(bus.rx_data), 32'hFF);
    chk("glitch_no_pending", 32'(q.size()), 32'h0);
    send(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 160);
    drive(1'b1, 128);
    chk("break_single_done", 32'(q.size()), 32'h0);
    send(8'h81, 1'b1, 1'b0);
    drive(1'b1, 64);
    drive(1'b0, 64);
    for (int i = 0; i < 4; i++) drive(a5[i], 64);
    drive(a5[4], 32);
    #1 rst_n = 1'b0;
    #2;
    chk("midreset_data", 32'(bus.rx_data), 32'h0);
    chk("midreset_done", 32'(bus.rx_done), 32'h0);
    chk("midreset_ferr", 32'(bus.frame_err), 32'h0);
    bus.rx = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 64);
    send(8'h5A, 1'b1, 1'b0);
    drive(1'b1, 64);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    send(8'h07, 1'b1, 1'b1);
    drive(1'b1, 64);
`endif
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
